// File: rtl/sha1_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha1_sequencer
// Brief    : Control and state block for the bit-serial SHA-1 mixer. Streams
//            one message block and the chaining state into the mixer, steps
//            80 rounds of 32 cycles with the round function and constant bits,
//            then folds the mixer result back into the 160-bit H register.
// Options  : SHA1_SEQ_MULTIBLOCK_EN adds the `first` input so H can chain
//            across blocks; without it every start reinitialises H.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         msg_in,
  output logic         msg_req,
  output logic         busy,
  output logic         done,
  output logic [159:0] digest,
  output logic [4:0]   step,
  output logic         w_en,
  output logic         w_in,
  output logic         a_en,
  output logic         a_in,
  output logic         c_rot,
  output logic [3:0]   f_sel,
  output logic         k_in,
  output logic         h_in,
  input  logic         h_out
`ifdef SHA1_SEQ_MULTIBLOCK_EN
  ,
  input  logic         first
`endif
);

  localparam logic [159:0] C_H_INIT =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [31:0] C_K0 = 32'h5A827999;
  localparam logic [31:0] C_K1 = 32'h6ED9EBA1;
  localparam logic [31:0] C_K2 = 32'h8F1BBCDC;
  localparam logic [31:0] C_K3 = 32'hCA62C1D6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_S = 3'd2,
    S_ROUND  = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [4:0]   r_bit_cnt;
  logic [6:0]   r_word_cnt;
  logic [159:0] r_h;
  logic         w_last_bit;
  logic         w_phase_end;
  logic [1:0]   w_group;
  logic [31:0]  w_k_word;
  logic         w_reinit;

`ifdef SHA1_SEQ_MULTIBLOCK_EN
  assign w_reinit = first;
`else
  assign w_reinit = 1'b1;
`endif

  assign w_last_bit = (r_bit_cnt == 5'd31);
  assign digest     = r_h;
  assign step       = (r_state == S_IDLE) ? 5'd0 : r_bit_cnt;

  // Last cycle of each serial phase: bit 31 of the phase's final word
  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_LOAD_W: w_phase_end = w_last_bit && (r_word_cnt == 7'd15);
      S_LOAD_S: w_phase_end = w_last_bit && (r_word_cnt == 7'd4);
      S_ROUND:  w_phase_end = w_last_bit && (r_word_cnt == 7'd79);
      S_UPDATE: w_phase_end = w_last_bit && (r_word_cnt == 7'd4);
      default:  w_phase_end = 1'b0;
    endcase
  end

  // Round group (0..3) and its constant, selected from the round number
  always_comb begin
    if (r_word_cnt < 7'd20)      w_group = 2'd0;
    else if (r_word_cnt < 7'd40) w_group = 2'd1;
    else if (r_word_cnt < 7'd60) w_group = 2'd2;
    else                         w_group = 2'd3;
    case (w_group)
      2'd0:    w_k_word = C_K0;
      2'd1:    w_k_word = C_K1;
      2'd2:    w_k_word = C_K2;
      default: w_k_word = C_K3;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and per-phase mixer strobes
  always_comb begin
    w_next_state = r_state;
    msg_req      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_en         = 1'b0;
    w_in         = 1'b0;
    a_en         = 1'b0;
    a_in         = 1'b0;
    c_rot        = 1'b0;
    f_sel        = 4'b0000;
    k_in         = 1'b0;
    h_in         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LOAD_W;
      end
      S_LOAD_W: begin
        busy    = 1'b1;
        msg_req = 1'b1;
        w_en    = 1'b1;
        w_in    = msg_in;
        if (w_phase_end) w_next_state = S_LOAD_S;
      end
      S_LOAD_S: begin
        busy = 1'b1;
        a_en = 1'b1;
        a_in = r_h[0];
        if (w_phase_end) w_next_state = S_ROUND;
      end
      S_ROUND: begin
        busy  = 1'b1;
        c_rot = 1'b1;
        f_sel = 4'b1000 >> w_group;
        k_in  = w_k_word[r_bit_cnt];
        if (w_phase_end) w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        busy = 1'b1;
        h_in = r_h[0];
        if (w_phase_end) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bit/word counters; cleared outside the serial phases and at each phase boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 5'd0;
      r_word_cnt <= 7'd0;
    end else if ((r_state == S_IDLE) || (r_state == S_DONE) || w_phase_end) begin
      r_bit_cnt  <= 5'd0;
      r_word_cnt <= 7'd0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 5'd1;
      if (w_last_bit) r_word_cnt <= r_word_cnt + 7'd1;
    end
  end

  // H register: rotated out during LOAD_S (H4 LSB first), refilled from mixer sum during UPDATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= C_H_INIT;
    end else begin
      case (r_state)
        S_IDLE:   if (start && w_reinit) r_h <= C_H_INIT;
        S_LOAD_S: r_h <= {r_h[0], r_h[159:1]};
        S_UPDATE: r_h <= {h_out, r_h[159:1]};
        default:  r_h <= r_h;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha1_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_sequencer
// Brief    : Self-checking bench for sha1_sequencer. A word-level mixer model
//            responds to the sequencer strobes; digests are compared against
//            known answers and a plain SHA-1 compression function.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_sequencer;

  localparam logic [159:0] H_INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam int RUN_CYC = 3393;

  logic         clk, rst_n, start, msg_in, h_out;
  logic         msg_req, busy, done, w_en, w_in, a_en, a_in, c_rot, k_in, h_in;
  logic [159:0] digest;
  logic [4:0]   step;
  logic [3:0]   f_sel;
`ifdef SHA1_SEQ_MULTIBLOCK_EN
  logic         first_drv;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  sha1_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_in(msg_in),
    .msg_req(msg_req), .busy(busy), .done(done), .digest(digest), .step(step),
    .w_en(w_en), .w_in(w_in), .a_en(a_en), .a_in(a_in), .c_rot(c_rot),
    .f_sel(f_sel), .k_in(k_in), .h_in(h_in), .h_out(h_out)
`ifdef SHA1_SEQ_MULTIBLOCK_EN
    , .first(first_drv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference functions ----------------
  function automatic logic [31:0] wexp_at(input logic [511:0] blk, input int t);
    logic [31:0] w [80];
    logic [31:0] x;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i <= t; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    return w[t];
  endfunction

  function automatic logic [159:0] ref_sha1(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] a, b, c, d, e, f, k, t;
    {a, b, c, d, e} = h;
    for (int r = 0; r < 80; r++) begin
      if (r < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (r < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (r < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + wexp_at(blk, r);
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // One round driven by whatever function select and constant the DUT presents
  function automatic logic [159:0] mix_round(input logic [159:0] s, input logic [31:0] wt,
                                             input logic [31:0] k, input logic [3:0] fs);
    logic [31:0] a, b, c, d, e, f, t;
    {a, b, c, d, e} = s;
    case (fs)
      4'b1000:          f = (b & c) | (~b & d);
      4'b0100, 4'b0001: f = b ^ c ^ d;
      4'b0010:          f = (b & c) | (b & d) | (c & d);
      default:          f = 32'h0;
    endcase
    t = {a[26:0], a[31:27]} + f + e + k + wt;
    return {t, a, {b[1:0], b[31:2]}, c, d};
  endfunction

  // ---------------- mixer model ----------------
  logic [511:0] feed_blk, mblk;
  logic [159:0] mstate;
  logic [31:0]  kacc;
  logic [31:0]  obs_k [80];
  logic [3:0]   obs_f [80];
  int           wcnt, scnt, rcnt, ucnt;
  logic         upd, carry, mbit;

  always_comb begin
    msg_in = 1'b0;
    if (wcnt < 512) msg_in = feed_blk[480 - 32*(wcnt/32) + (wcnt%32)];
  end

  always_comb begin
    mbit  = 1'b0;
    h_out = 1'b0;
    if (upd && ucnt < 160) begin
      mbit  = mstate[ucnt];
      h_out = h_in ^ mbit ^ carry;
    end
  end

  // Word-level mixer: captures W and a..e, applies rounds, adds serially on update
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0; scnt <= 0; rcnt <= 0; ucnt <= 0; upd <= 1'b0; carry <= 1'b0; kacc <= '0;
    end else if (start && !busy && !done) begin
      wcnt <= 0; scnt <= 0; rcnt <= 0; ucnt <= 0; upd <= 1'b0; carry <= 1'b0;
    end else begin
      if (w_en && wcnt < 512) begin
        mblk[480 - 32*(wcnt/32) + (wcnt%32)] <= w_in;
        wcnt <= wcnt + 1;
      end
      if (a_en && scnt < 160) begin
        mstate[scnt] <= a_in;
        scnt <= scnt + 1;
      end
      if (c_rot && rcnt < 80) begin
        kacc[step] <= k_in;
        if (step == 5'd31) begin
          mstate      <= mix_round(mstate, wexp_at(mblk, rcnt), {k_in, kacc[30:0]}, f_sel);
          obs_k[rcnt] <= {k_in, kacc[30:0]};
          obs_f[rcnt] <= f_sel;
          rcnt        <= rcnt + 1;
          if (rcnt == 79) begin
            upd <= 1'b1; ucnt <= 0; carry <= 1'b0;
          end
        end
      end
      if (upd) begin
        carry <= (step == 5'd31) ? 1'b0 : ((h_in & mbit) | (h_in & carry) | (mbit & carry));
        ucnt  <= ucnt + 1;
        if (ucnt == 159) upd <= 1'b0;
      end
    end
  end

  // ---------------- run helper ----------------
  int done_cyc, busy_cnt, req_cnt, aen_cnt, crot_cnt;

  task automatic run_block(input logic [511:0] blk, input bit poke);
    int n;
    feed_blk = blk;
    done_cyc = -1; busy_cnt = 0; req_cnt = 0; aen_cnt = 0; crot_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < 4000 && done_cyc < 0) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (poke && (n == 100 || n == 2000 || n == 3392)) start = 1'b1;
      if (busy)    busy_cnt++;
      if (msg_req) req_cnt++;
      if (a_en)    aen_cnt++;
      if (c_rot)   crot_cnt++;
      if (done) begin
        done_cyc = n;
        if (poke) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_done: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bcnt;
    rst_n = 1'b0; start = 1'b0; feed_blk = '0;
    #12;
    tests_run++;
    if ({msg_req, busy, done, w_en, w_in, a_en, a_in, c_rot, k_in, h_in, f_sel, step} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required all zero",
               {msg_req, busy, done, w_en, w_in, a_en, a_in, c_rot, k_in, h_in, f_sel, step});
    end
    tests_run++;
    if (digest !== H_INIT) begin
      tests_failed++;
      $display("FAIL reset_digest: got %h required %h", digest, H_INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy || done || msg_req) bcnt++;
    end
    tests_run++;
    if (bcnt !== 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: active cycles %0d required 0", bcnt);
    end
  endtask

  task automatic check_run(input string nm, input logic [159:0] exp_dig);
    tests_run++;
    if (done_cyc !== RUN_CYC) begin
      tests_failed++;
      $display("FAIL %s_done_cycle: got %0d required %0d", nm, done_cyc, RUN_CYC);
    end
    tests_run++;
    if (digest !== exp_dig) begin
      tests_failed++;
      $display("FAIL %s_digest: got %h required %h", nm, digest, exp_dig);
    end
  endtask

  task automatic test_abc();
    logic [511:0] blk;
    blk = '0;
    blk[511:480] = 32'h61626380;
    blk[31:0]    = 32'h00000018;
    run_block(blk, 1'b0);
    check_run("abc", 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
    tests_run++;
    if (busy_cnt !== 3392 || req_cnt !== 512 || aen_cnt !== 160 || crot_cnt !== 2560) begin
      tests_failed++;
      $display("FAIL abc_phase_lengths: busy=%0d req=%0d a_en=%0d c_rot=%0d required 3392 512 160 2560",
               busy_cnt, req_cnt, aen_cnt, crot_cnt);
    end
  endtask

  task automatic test_control_trace();
    logic [31:0] ktab [4];
    logic [3:0]  ef;
    ktab[0] = 32'h5A827999; ktab[1] = 32'h6ED9EBA1; ktab[2] = 32'h8F1BBCDC; ktab[3] = 32'hCA62C1D6;
    tests_run++;
    if (obs_f[19] !== 4'b1000 || obs_f[20] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL fsel_19_20: got %b %b required 1000 0100", obs_f[19], obs_f[20]);
    end
    tests_run++;
    if (obs_k[0] !== 32'h5A827999) begin
      tests_failed++;
      $display("FAIL k_round0: got %h required 5a827999", obs_k[0]);
    end
    for (int r = 0; r < 80; r++) begin
      ef = 4'b1000 >> (r / 20);
      tests_run++;
      if (obs_f[r] !== ef || obs_k[r] !== ktab[r/20]) begin
        tests_failed++;
        $display("FAIL round_ctrl[%0d]: f=%b k=%h required f=%b k=%h", r, obs_f[r], obs_k[r], ef, ktab[r/20]);
      end
    end
  endtask

  task automatic test_empty();
    logic [511:0] blk;
    blk = '0;
    blk[511:480] = 32'h80000000;
    run_block(blk, 1'b0);
    check_run("empty", 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
  endtask

  task automatic test_random();
    logic [511:0] blk;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
      run_block(blk, 1'b0);
      check_run("random", ref_sha1(H_INIT, blk));
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk;
    int extra;
    // start poked mid-run and during DONE must not launch another block
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    run_block(blk, 1'b1);
    check_run("poked", ref_sha1(H_INIT, blk));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL start_in_done_ignored: active cycles %0d required 0", extra);
    end
  endtask

  task automatic test_abort();
    logic [511:0] blk;
    int n, act;
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    feed_blk = blk;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < 1953) begin
      @(negedge clk);
      n++;
      start = (n == 50 || n == 1000) ? 1'b1 : 1'b0;
    end
    tests_run++;
    if (f_sel !== 4'b0010 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL round40_ctrl: f_sel=%b busy=%b required 0010 1", f_sel, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || digest !== H_INIT) begin
      tests_failed++;
      $display("FAIL abort_state: busy=%b done=%b digest=%h required 0 0 %h", busy, done, digest, H_INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 3600; i++) begin
      @(negedge clk);
      if (busy || done) act++;
    end
    tests_run++;
    if (act !== 0 || digest !== H_INIT) begin
      tests_failed++;
      $display("FAIL abort_quiet: active %0d digest %h required 0 %h", act, digest, H_INIT);
    end
    test_abc();
  endtask

`ifdef SHA1_SEQ_MULTIBLOCK_EN
  task automatic test_multiblock();
    logic [511:0] b1, b2;
    b1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    b2 = '0;
    b2[31:0] = 32'h000001c0;
    first_drv = 1'b1;
    run_block(b1, 1'b0);
    check_run("multi_b1", ref_sha1(H_INIT, b1));
    first_drv = 1'b0;
    run_block(b2, 1'b0);
    check_run("multi_b2", 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);
    first_drv = 1'b1;
  endtask
`endif

  initial begin
`ifdef SHA1_SEQ_MULTIBLOCK_EN
    first_drv = 1'b1;
`endif
    test_reset();
    test_abc();
    test_control_trace();
    test_empty();
    test_random();
    test_back_to_back();
    test_abort();
`ifdef SHA1_SEQ_MULTIBLOCK_EN
    test_multiblock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
